// File: rtl/usb_rx_decoder.sv
// HS receive path after data recovery: NRZI decode, SYNC hunt, bit-unstuffing,
// EOP (stuff violation) detection and LSB-first byte assembly.
//
// state | meaning
// HUNT  | waiting for a long run of decoded 0s terminated by a 1 (SYNC)
// DATA  | inside a packet, unstuffing and assembling bytes
// DRAIN | babble seen, silently waiting for the next EOP
module usb_rx_decoder #(
  parameter int SYNC_MIN_ZEROS = 12,
  parameter int STUFF_RUN      = 6,
  parameter int MAX_PKT_BYTES  = 1027
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error
);

  localparam int RW = $clog2(STUFF_RUN + 2);
  localparam logic [RW-1:0] RUN_EOP  = RW'(STUFF_RUN);
  localparam logic [RW-1:0] RUN_SAT  = RW'(STUFF_RUN + 1);
  localparam logic [4:0]    SYNC_MIN = 5'(SYNC_MIN_ZEROS);
  localparam logic [10:0]   PKT_MAX  = 11'(MAX_PKT_BYTES);

  typedef enum logic [1:0] {HUNT, DATA, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          prev_q, prev_d;
  logic [RW-1:0] ones_q, ones_d;
  logic [4:0]    zero_q, zero_d;
  logic [2:0]    bit_q, bit_d;
  logic [10:0]   byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          active_q, active_d;
  logic          error_q, error_d;
  logic          dec;

  assign dec = ~(bit_in ^ prev_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      prev_q   <= 1'b1;
      ones_q   <= '0;
      zero_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      ones_q   <= ones_d;
      zero_q   <= zero_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    ones_d   = ones_q;
    zero_d   = zero_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    active_d = active_q;
    error_d  = 1'b0;

    if (bit_valid) begin
      prev_d = bit_in;
      if (dec) ones_d = (ones_q == RUN_SAT) ? ones_q : ones_q + RW'(1);
      else     ones_d = '0;

      case (state_q)
        HUNT: begin
          if (!dec) begin
            zero_d = (zero_q == 5'd31) ? zero_q : zero_q + 5'd1;
          end else begin
            zero_d = '0;
            if (zero_q >= SYNC_MIN) begin
              state_d  = DATA;
              bit_d    = '0;
              byte_d   = '0;
              ones_d   = '0;
              active_d = 1'b1;
            end
          end
        end
        DATA: begin
          if (ones_q == RUN_EOP && dec) begin
            // a good EOP leaves exactly 7 unstuffed bits (0 + six 1s) pending
            state_d  = HUNT;
            active_d = 1'b0;
            error_d  = (bit_q != 3'd7);
          end else if (ones_q != RUN_EOP) begin
            shift_d = {dec, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (byte_q == PKT_MAX) begin
                state_d  = DRAIN;
                active_d = 1'b0;
                error_d  = 1'b1;
              end else begin
                data_d  = {dec, shift_q[7:1]};
                valid_d = 1'b1;
                byte_d  = byte_q + 11'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (ones_q == RUN_EOP && dec) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_active = active_q;
  assign rx_error  = error_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: NRZI/stuffing encoder drives the line,
// expected bytes and their strobe cycles are queued and matched by a monitor.
module tb_usb_rx_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   drv_cyc = 0;
  int   byte_end_cyc = 0;
  int   err_cnt = 0;
  int   err_cyc = -1;
  logic err_active = 1'b0;
  logic lvl = 1'b1;
  int   stuff_cnt = 0;
  bit   gap_en = 1'b0;

  usb_rx_decoder #(.MAX_PKT_BYTES(4)) dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active), .rx_error(rx_error)
  );

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: every strobe must match the head of the scoreboard, on the predicted cycle
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rx_valid", {31'b0, rx_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        chk("rx_valid_cycle", cyc, e.cyc);
      end
    end
    if (rx_error) begin
      err_cnt++;
      err_cyc    = cyc;
      err_active = rx_active;
    end
  end

  task automatic drive(input logic v, input logic lv);
    @(negedge clock);
    bit_valid = v;
    bit_in    = lv;
    drv_cyc   = cyc + 1;
  endtask

  task automatic send_raw(input logic d);
    if (gap_en && (cyc % 3 == 0)) drive(1'b0, ~lvl);
    if (!d) lvl = ~lvl;
    drive(1'b1, lvl);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, lvl);
  endtask

  task automatic idle_j(input int n);
    repeat (n) send_raw(1'b1);
  endtask

  task automatic send_sync(input int nz);
    repeat (nz) send_raw(1'b0);
    send_raw(1'b1);
    stuff_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    for (int i = 0; i < 8; i++) begin
      send_raw(b[i]);
      if (i == 7) begin
        byte_end_cyc = drv_cyc;
        if (push) exp_q.push_back('{data: b, cyc: drv_cyc});
      end
      if (b[i]) begin
        stuff_cnt++;
        if (stuff_cnt == 6) begin
          send_raw(1'b0);
          stuff_cnt = 0;
        end
      end else begin
        stuff_cnt = 0;
      end
    end
  endtask

  task automatic send_eop();
    send_raw(1'b0);
    repeat (7) send_raw(1'b1);
    stuff_cnt = 0;
  endtask

  initial begin
    int e0;
    int ecyc;
    reset     = 1'b0;
    bit_in    = 1'b1;
    bit_valid = 1'b0;
    #12;
    chk("reset_rx_data",   {24'b0, rx_data}, 32'h00);
    chk("reset_rx_valid",  {31'b0, rx_valid}, 32'd0);
    chk("reset_rx_active", {31'b0, rx_active}, 32'd0);
    chk("reset_rx_error",  {31'b0, rx_error}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // 1: basic packet
    e0 = err_cnt;
    idle_j(4);
    send_sync(31);
    chk("t1_active_before_sync", {31'b0, rx_active}, 32'd0);
    idle(1);
    chk("t1_active_after_sync", {31'b0, rx_active}, 32'd1);
    send_byte(8'hA5, 1);
    send_byte(8'h3C, 1);
    send_eop();
    chk("t1_active_at_eop", {31'b0, rx_active}, 32'd1);
    idle(1);
    chk("t1_active_after_eop", {31'b0, rx_active}, 32'd0);
    idle(3);
    chk("t1_rx_data_held", {24'b0, rx_data}, 32'h3C);
    chk("t1_pending", exp_q.size(), 32'd0);
    chk("t1_errors", err_cnt - e0, 32'd0);

    // 2: stuffing, then a stuff violation mid-packet
    e0 = err_cnt;
    idle_j(4);
    send_sync(31);
    send_byte(8'hFF, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h00, 1);
    send_eop();
    idle(3);
    chk("t2_pending", exp_q.size(), 32'd0);
    chk("t2_errors", err_cnt - e0, 32'd0);
    idle_j(4);
    send_sync(31);
    repeat (6) send_raw(1'b1);
    send_raw(1'b1);
    ecyc = drv_cyc;
    send_raw(1'b1);
    send_byte(8'h00, 0);
    idle(3);
    chk("t2v_errors", err_cnt - e0, 32'd1);
    chk("t2v_err_cycle", err_cyc, ecyc);
    chk("t2v_active_at_err", {31'b0, err_active}, 32'd0);
    chk("t2v_active_after", {31'b0, rx_active}, 32'd0);

    // 3: short SYNC rejected, minimum SYNC accepted
    e0 = err_cnt;
    idle_j(4);
    send_sync(8);
    send_byte(8'hA5, 0);
    chk("t3_short_active", {31'b0, rx_active}, 32'd0);
    send_byte(8'h3C, 0);
    send_eop();
    idle(2);
    chk("t3_short_active_end", {31'b0, rx_active}, 32'd0);
    idle_j(4);
    send_sync(12);
    send_byte(8'h5A, 1);
    send_eop();
    idle(3);
    chk("t3_pending", exp_q.size(), 32'd0);
    chk("t3_errors", err_cnt - e0, 32'd0);

    // 4: EOP after a partial byte
    e0 = err_cnt;
    idle_j(4);
    send_sync(31);
    send_byte(8'hA5, 1);
    repeat (3) send_raw(1'b1);
    chk("t4_active_before_eop", {31'b0, rx_active}, 32'd1);
    repeat (3) send_raw(1'b1);
    ecyc = drv_cyc;
    idle(3);
    chk("t4_errors", err_cnt - e0, 32'd1);
    chk("t4_err_cycle", err_cyc, ecyc);
    chk("t4_active_at_err", {31'b0, err_active}, 32'd0);
    chk("t4_pending", exp_q.size(), 32'd0);

    // 5: babble with a 4-byte limit, then recovery
    e0 = err_cnt;
    idle_j(4);
    send_sync(31);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    send_byte(8'h55, 0);
    ecyc = byte_end_cyc;
    send_byte(8'h66, 0);
    chk("t5_active_drain", {31'b0, rx_active}, 32'd0);
    send_eop();
    idle(2);
    chk("t5_errors", err_cnt - e0, 32'd1);
    chk("t5_err_cycle", err_cyc, ecyc);
    chk("t5_active_at_err", {31'b0, err_active}, 32'd0);
    idle_j(4);
    send_sync(31);
    send_byte(8'h96, 1);
    send_eop();
    idle(3);
    chk("t5_pending", exp_q.size(), 32'd0);
    chk("t5_errors_after", err_cnt - e0, 32'd1);

    // 6: gapped bit_valid, then reset mid-byte
    e0 = err_cnt;
    gap_en = 1'b1;
    idle_j(4);
    send_sync(31);
    send_byte(8'hA5, 1);
    send_byte(8'h3C, 1);
    send_eop();
    idle(3);
    chk("t6_pending", exp_q.size(), 32'd0);
    chk("t6_errors", err_cnt - e0, 32'd0);
    idle_j(4);
    send_sync(31);
    repeat (4) send_raw(1'b1);
    chk("t6_active_before_reset", {31'b0, rx_active}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_reset_active", {31'b0, rx_active}, 32'd0);
    chk("t6_reset_data", {24'b0, rx_data}, 32'h00);
    chk("t6_reset_error", {31'b0, rx_error}, 32'd0);
    gap_en = 1'b0;
    idle(3);
    lvl = 1'b1;
    stuff_cnt = 0;
    drive(1'b0, lvl);
    reset = 1'b1;
    idle(2);
    send_sync(12);
    send_byte(8'hC3, 1);
    send_eop();
    idle(3);
    chk("t6_post_reset_pending", exp_q.size(), 32'd0);
    chk("t6_post_reset_errors", err_cnt - e0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
